// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: driver FSM states, command bundle, limits.
package conv_pkg;
  localparam int MAX_KERNEL_DEF = 16;
  localparam int BEAT_W         = 16;

  typedef enum logic [2:0] {IDLE, FLUSH, LOAD_WT, WAIT_KB, STREAM, DRAIN} mc_state_e;

  typedef struct packed {
    logic [7:0]        kernel_size;
    logic [BEAT_W-1:0] num_ifmap;
  } mc_cmd_t;

  function automatic logic size_ok(input logic [7:0] ks, input int max_k);
    return (ks != 8'd0) && (int'(ks) <= max_k);
  endfunction
endpackage

// File: rtl/mc_beat_cnt.sv
// Load / increment / terminal-count beat counter; saturates instead of wrapping.
module mc_beat_cnt
  import conv_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] limit,
  input  logic         inc,
  output logic         last,
  output logic         empty
);
  logic [W-1:0] count;
  logic [W-1:0] lim_q;
  logic [W:0]   nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      lim_q <= '0;
    end else if (load) begin
      count <= '0;
      lim_q <= limit;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // last: the beat being accepted now is the final one
  assign nxt   = {1'b0, count} + {{W{1'b0}}, 1'b1};
  assign last  = (nxt == {1'b0, lim_q});
  assign empty = (lim_q == '0);
endmodule

// File: rtl/mc_bus_driver.sv
// Drives the MultiCaster bus: flush, weight load, kernel-busy wait, ifmap stream, drain.
// Optional watchdog on WAIT_KB/DRAIN enabled by defining MC_BUS_DRIVER_TIMEOUT_EN.
module mc_bus_driver
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_COL    = 4,
  parameter  int MAX_KERNEL = MAX_KERNEL_DEF,
  parameter  int TO_CYCLES  = 1024,
  localparam int IDW        = $clog2(NUM_COL) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [7:0]            cfg_kernel_size,
  input  logic [15:0]           cfg_num_ifmap,
  input  logic [IDW-1:0]        cfg_id,
  input  logic [DATA_WIDTH-1:0] wt_data,
  input  logic                  wt_valid,
  output logic                  wt_ready,
  input  logic [DATA_WIDTH-1:0] if_data,
  input  logic                  if_valid,
  output logic                  if_ready,
  output logic                  bus_flush_kernel,
  output logic                  bus_flush_tag,
  output logic [7:0]            bus_kernel_size,
  output logic [IDW-1:0]        bus_id,
  output logic [DATA_WIDTH-1:0] bus_fltr_data,
  output logic                  bus_fltr_valid,
  output logic [DATA_WIDTH-1:0] bus_ifmap_data,
  output logic                  bus_ifmap_valid,
  input  logic                  bus_kernel_busy,
  input  logic                  bus_valid,
  output logic                  done,
  output logic                  err
);
  mc_state_e state, nxt_state;
  mc_cmd_t   cmd;
  logic      act, wkb_seen;
  logic      cfg_hs, cmd_ok, accept, wt_hs, if_hs;
  logic      wt_last, wt_empty, if_last, if_empty;
  logic      reject, tmo, to_hit;

  assign cmd    = '{kernel_size: cfg_kernel_size, num_ifmap: cfg_num_ifmap};
  assign cfg_hs = cfg_valid && cfg_ready;
  assign cmd_ok = size_ok(cmd.kernel_size, MAX_KERNEL);
  assign accept = cfg_hs && cmd_ok;
  assign wt_hs  = wt_valid && wt_ready;
  assign if_hs  = if_valid && if_ready;

  mc_beat_cnt #(.W(BEAT_W)) u_wt_cnt (
    .clk(clk), .rstn(rstn), .load(accept), .limit({8'h00, cmd.kernel_size}),
    .inc(wt_hs), .last(wt_last), .empty(wt_empty)
  );

  mc_beat_cnt #(.W(BEAT_W)) u_if_cnt (
    .clk(clk), .rstn(rstn), .load(accept), .limit(cmd.num_ifmap),
    .inc(if_hs), .last(if_last), .empty(if_empty)
  );

`ifdef MC_BUS_DRIVER_TIMEOUT_EN
  localparam int TOW = $clog2(TO_CYCLES + 1);
  logic [TOW-1:0] to_cnt;

  // restarts on every state change so each waiting state gets the full budget
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      to_cnt <= '0;
    else if ((state != nxt_state) || !((state == WAIT_KB) || (state == DRAIN)))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == TOW'(TO_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TO_CYCLES;
  assign to_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      act      <= 1'b0;
      wkb_seen <= 1'b0;
    end else begin
      state    <= nxt_state;
      act      <= 1'b1;
      wkb_seen <= (state == WAIT_KB);
    end
  end

  always_comb begin
    nxt_state = state;
    reject    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE:    if (cfg_hs) begin
                 if (cmd_ok) nxt_state = FLUSH;
                 else        reject    = 1'b1;
               end
      FLUSH:   nxt_state = wt_empty ? WAIT_KB : LOAD_WT;
      LOAD_WT: if (wt_hs && wt_last) nxt_state = WAIT_KB;
      // busy is ignored on the entry cycle: the caster has not yet seen the last weight
      WAIT_KB: if (wkb_seen && !bus_kernel_busy) nxt_state = if_empty ? DRAIN : STREAM;
               else if (to_hit) begin
                 nxt_state = IDLE;
                 tmo       = 1'b1;
               end
      STREAM:  if (if_hs && if_last) nxt_state = DRAIN;
      DRAIN:   if (bus_valid) nxt_state = IDLE;
               else if (to_hit) begin
                 nxt_state = IDLE;
                 tmo       = 1'b1;
               end
      default: nxt_state = IDLE;
    endcase
  end

  assign cfg_ready        = act && (state == IDLE);
  assign wt_ready         = (state == LOAD_WT);
  assign if_ready         = (state == STREAM);
  assign bus_flush_kernel = (state == FLUSH);
  assign bus_flush_tag    = (state == FLUSH);
  assign done             = (state == DRAIN) && bus_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_kernel_size <= '0;
      bus_id          <= '0;
      bus_fltr_data   <= '0;
      bus_fltr_valid  <= 1'b0;
      bus_ifmap_data  <= '0;
      bus_ifmap_valid <= 1'b0;
      err             <= 1'b0;
    end else begin
      if (accept) begin
        bus_kernel_size <= cmd.kernel_size;
        bus_id          <= cfg_id;
      end
      bus_fltr_valid  <= wt_hs;
      if (wt_hs) bus_fltr_data <= wt_data;
      bus_ifmap_valid <= if_hs;
      if (if_hs) bus_ifmap_data <= if_data;
      err             <= reject || tmo;
    end
  end
endmodule

// File: doc/mc_bus_driver.md
MC_BUS_DRIVER -- requirements
Module: mc_bus_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the ifmap/filter word width.
REQ-002 SHALL have parameter NUM_COL, default 4, the number of columns; IDW = $clog2(NUM_COL)+1.
REQ-003 SHALL have parameter MAX_KERNEL, default 16, equal to the MultiCaster weight-buffer depth.
REQ-004 SHALL have parameter TO_CYCLES, default 1024, the watchdog limit.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 cfg_valid/cfg_ready  in/out  1/1  command handshake.
REQ-008 cfg_kernel_size  in  8  weight count; cfg_num_ifmap  in  16  ifmap word count; cfg_id  in  IDW  target ID.
REQ-009 wt_data/wt_valid/wt_ready  in/in/out  DATA_WIDTH/1/1  upstream weight stream.
REQ-010 if_data/if_valid/if_ready  in/in/out  DATA_WIDTH/1/1  upstream ifmap stream.
REQ-011 bus_flush_kernel, bus_flush_tag  out  1  one-cycle flush strobes toward the MultiCaster.
REQ-012 bus_kernel_size  out  8; bus_id  out  IDW; bus_fltr_data/bus_fltr_valid  out  DATA_WIDTH/1; bus_ifmap_data/bus_ifmap_valid  out  DATA_WIDTH/1.
REQ-013 bus_kernel_busy  in  1; bus_valid  in  1  (the AND of all caster VALIDs).
REQ-014 done, err  out  1  one-cycle completion and error pulses.

Function
REQ-015 The FSM SHALL have the states IDLE, FLUSH, LOAD_WT, WAIT_KB, STREAM, DRAIN.
REQ-016 IDLE: cfg_ready=1; on handshake, the block SHALL latch size, count and id, and go to FLUSH.
REQ-017 If cfg_kernel_size is 0 or greater than MAX_KERNEL, the command SHALL be rejected: err pulses the next cycle and the FSM stays in IDLE.
REQ-018 FLUSH lasts exactly 1 cycle: bus_flush_kernel=bus_flush_tag=1; bus_kernel_size and bus_id SHALL be valid that cycle and held until the next command.
REQ-019 LOAD_WT: wt_ready=1; each wt handshake SHALL register bus_fltr_data and pulse bus_fltr_valid 1 cycle later; after kernel_size beats, go to WAIT_KB; gaps in wt_valid SHALL stall without loss.
REQ-020 WAIT_KB SHALL go to STREAM on the first cycle with bus_kernel_busy=0, no earlier than 1 cycle after entry.
REQ-021 STREAM: if_ready=1; ifmap data SHALL be registered and valid with 1-cycle latency; after cfg_num_ifmap beats, go to DRAIN; count 0 SHALL skip directly to DRAIN.
REQ-022 DRAIN SHALL wait for bus_valid=1, then pulse done and return to IDLE; done and cfg_ready SHALL never be 1 in the same cycle.
REQ-023 wt_ready and if_ready SHALL be 0 outside LOAD_WT and STREAM respectively; cfg_valid outside IDLE SHALL be ignored.
REQ-024 Beat counters SHALL be 16 bits, compare against latched values, and never wrap.

Reset
REQ-025 When rstn=0, the block SHALL set state=IDLE; all bus_* outputs, done, err, wt_ready and if_ready to 0; cfg_ready to 1 after release; counters and latches to 0.
REQ-026 A reset in the middle of any state SHALL abort the command with no flush or done pulse.

Configuration
REQ-027 With MC_BUS_DRIVER_TIMEOUT_EN defined, the block SHALL count cycles in WAIT_KB and DRAIN; on reaching TO_CYCLES it SHALL pulse err and go to IDLE.
REQ-028 Without MC_BUS_DRIVER_TIMEOUT_EN, the block SHALL wait indefinitely and omit the watchdog counter.

Structure
REQ-029 The state enum typedef and the MAX_KERNEL default SHALL reside in the shared package conv_pkg.
REQ-030 The block SHALL contain one sub-module, mc_beat_cnt, a load/increment/terminal-count counter instantiated once for weights and once for ifmap.

Verification
REQ-031 The bench SHALL cover: kernel_size=9, 9 weights back-to-back -> flush strobes 1 cycle, 9 bus_fltr_valid pulses, WAIT_KB entered.
REQ-032 The bench SHALL cover: weights with wt_valid toggling every other cycle -> all 9 values delivered in order, none duplicated.
REQ-033 The bench SHALL cover: kernel_busy held for 5 cycles, then 0, num_ifmap=32 -> 32 ifmap beats; bus_valid after 3 cycles -> done exactly once.
REQ-034 The bench SHALL cover: cfg_kernel_size=17 -> err pulse, no flush, cfg_ready stays 1.
REQ-035 The bench SHALL cover: rstn asserted during STREAM at beat 10 -> all outputs 0 immediately, IDLE after release, and a new command completes normally.
REQ-036 The bench SHALL cover, with MC_BUS_DRIVER_TIMEOUT_EN defined: bus_valid never asserted -> err pulse after 1024 DRAIN cycles, return to IDLE.
